pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM).
//  Detects load-use hazards, taken-branch/jump redirects and data-memory wait states.
//  Drives per-stage write-enable, flush and hold controls.
//  Sits beside the hazard/forwarding logic; the ID/EX register gains a hold input and is driven by it.
// PARAMETERS
//  LOAD_DELAY   1    load-use stall length in cycles (1..3)
//  MEM_TIMEOUT  255  consecutive memory-wait cycles before HALT; 0 disables timeout
//  CNT_W        32   width of performance counters
// PORTS
//  clk             in   1      clock
//  reset           in   1      async, active-high
//  id_rs, id_rt    in   5      source register numbers of instruction in ID
//  id_use_rs/rt    in   1      ID instruction actually reads rs / rt
//  id_jump         in   1      jump (J/JAL/JR/JALR) resolved in ID
//  ex_dst          in   5      destination register of instruction in EX
//  ex_mem_read     in   1      instruction in EX is a load
//  ex_branch_taken in   1      branch in EX resolved taken
//  mem_req         in   1      MEM stage has an active data-memory access
//  mem_ready       in   1      data memory completes access this cycle
//  pc_write        out  1      PC register write enable
//  if_id_write     out  1      IF/ID write enable
//  if_id_flush     out  1      IF/ID load NOP
//  id_ex_flush     out  1      ID/EX load bubble (all control fields 0)
//  id_ex_hold      out  1      ID/EX keeps contents
//  ex_mem_hold     out  1      EX/MEM keeps contents
//  state           out  2      current FSM state
//  err_timeout     out  1      sticky; memory timeout occurred
// BEHAVIOUR
//  Reset is asynchronous. While reset is high:
//   - state=RUN, err_timeout=0, counters=0.
//   - pc_write=1, if_id_write=1; all flush and hold outputs 0.
//  Outputs are combinational from state and inputs; same-cycle response.
//  Hazard terms:
//   - lu = ex_mem_read & ex_dst!=0 & ((id_use_rs & id_rs==ex_dst) | (id_use_rt & id_rt==ex_dst))
//   - mw = mem_req & ~mem_ready
//  Priority, highest first:
//   HALT > mw > ex_branch_taken > lu / LU_STALL > id_jump.
//  Actions:
//   mw freeze: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, no flush.
//     The EX branch is held with ID/EX and is applied on the first cycle after mw clears.
//   branch:    pc_write=1, if_id_flush=1, id_ex_flush=1. Any lu/jump is discarded; LU_STALL is abandoned.
//   lu stall:  pc_write=0, if_id_write=0, id_ex_flush=1.
//   jump:      if_id_flush=1, pc_write=1.
//  FSM states: RUN=0, LU_STALL=1, MEM_WAIT=2, HALT=3.
//   - RUN -> LU_STALL: on lu (no higher event) when LOAD_DELAY>1; loads lu_cnt=LOAD_DELAY-2.
//   - LU_STALL: applies lu stall every cycle.
//       -> RUN when lu_cnt==0; else lu_cnt decrements.
//       -> RUN immediately on branch.
//   - RUN/LU_STALL -> MEM_WAIT: on mw. wait_cnt increments each mw cycle.
//       LU_STALL progress (lu_cnt) is frozen during MEM_WAIT.
//   - MEM_WAIT -> prior state (RUN or LU_STALL): when mw clears; wait_cnt cleared.
//   - MEM_WAIT -> HALT: after MEM_TIMEOUT consecutive mw cycles (MEM_TIMEOUT!=0).
//   - HALT: mw freeze forced, err_timeout=1; exits only via reset.
//  wait_cnt saturates; width = clog2(MEM_TIMEOUT+1).
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - adds outputs stall_cnt[CNT_W] (lu + mw cycles) and flush_cnt[CNT_W] (branch + jump flush cycles).
//   - counters saturate at all-ones; reset to 0.
//  HAZARD_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package pipe_ctrl_pkg:
//   - state enum (RUN/LU_STALL/MEM_WAIT/HALT)
//   - REG_ZERO=5'd0
//   - stage-control struct type
//  Sub-module hazard_match: combinational lu comparator (rs/rt vs ex_dst, zero-reg exclusion).
// TESTING
//  1. ex_mem_read=1, ex_dst=8, id_rs=8, id_use_rs=1, LOAD_DELAY=1
//     -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle normal.
//  2. Same stimulus but ex_dst=0, or id_use_rs=0 -> no stall.
//  3. lu and ex_branch_taken together
//     -> pc_write=1, if_id_flush=1, id_ex_flush=1; state stays RUN.
//  4. LOAD_DELAY=3 on lu -> 3 stall cycles.
//     mw during 2nd cycle for 2 cycles -> holds only, then remaining stall cycle.
//  5. MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held
//     -> 4 freeze cycles, then state=HALT, err_timeout=1 persists.
//     Async reset -> RUN, err_timeout=0 immediately.
//  6. HAZARD_PERF_EN: 1 lu + 3 mw + 1 branch -> stall_cnt=4, flush_cnt=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e      : controller FSM state (RUN / LU_STALL / MEM_WAIT / HALT)
//   REG_ZERO     : hard-wired zero register number, never a hazard source
//   stage_ctrl_t : bundle of per-stage pipeline register controls
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Field order is MSB first, so the action constants below read left to right.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic id_ex_hold;
    logic ex_mem_hold;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = 6'b110000;
  localparam stage_ctrl_t CTRL_FREEZE = 6'b000011;
  localparam stage_ctrl_t CTRL_BRANCH = 6'b111100;
  localparam stage_ctrl_t CTRL_STALL  = 6'b000100;
  localparam stage_ctrl_t CTRL_JUMP   = 6'b111000;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// hazard_match: combinational load-use comparator.
// Flags a load-use hazard when the instruction in EX is a load whose
// destination (other than the zero register) is read by the instruction in ID.
//   id_rs_i, id_rt_i         : ID source register numbers
//   id_use_rs_i, id_use_rt_i : ID instruction really reads rs / rt
//   ex_dst_i                 : EX destination register
//   ex_mem_read_i            : EX instruction is a load
//   lu_o                     : load-use hazard
module hazard_match
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  input  logic [4:0] ex_dst_i,
  input  logic       ex_mem_read_i,
  output logic       lu_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_use_rs_i & (id_rs_i == ex_dst_i);
  assign rt_hit = id_use_rt_i & (id_rt_i == ex_dst_i);
  assign lu_o   = ex_mem_read_i & (ex_dst_i != REG_ZERO) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequences PC, IF/ID, ID/EX and EX/MEM registers of a
// 5-stage pipeline. Handles load-use stalls, branch/jump redirects and
// data-memory wait states; a memory access stuck for MEM_TIMEOUT cycles halts
// the pipeline until reset.
// Ports:
//   clk, reset (async, active-high)
//   id_rs, id_rt, id_use_rs, id_use_rt, id_jump : ID stage info
//   ex_dst, ex_mem_read, ex_branch_taken         : EX stage info
//   mem_req, mem_ready                           : MEM stage handshake
//   pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold
//                                                : stage controls (combinational)
//   state                                        : current FSM state
//   err_timeout                                  : sticky memory timeout flag
// Optional feature macro HAZARD_PERF_EN adds saturating counters
//   stall_cnt (load-use + memory-wait cycles) and flush_cnt (branch + jump flushes).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_DELAY  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_dst,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic [1:0]       state,
  output logic             err_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W:0] TIMEOUT_V = MEM_TIMEOUT[WAIT_W:0];
  // lu_cnt counts the stall cycles still owed after the next one.
  localparam logic [1:0] LU_RELOAD = (LOAD_DELAY > 1) ? 2'(LOAD_DELAY - 2) : 2'd0;

  state_e            state_q, state_d;
  state_e            prior_q, prior_d;
  state_e            eff_state;
  logic [1:0]        lu_cnt_q, lu_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_W:0]   wait_next;
  logic              err_q, err_d;
  logic              lu, mw;
  stage_ctrl_t       ctrl, ctrl_out;

  hazard_match u_match (
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_use_rs_i   (id_use_rs),
    .id_use_rt_i   (id_use_rt),
    .ex_dst_i      (ex_dst),
    .ex_mem_read_i (ex_mem_read),
    .lu_o          (lu)
  );

  assign mw = mem_req & ~mem_ready;

  always_comb begin
    state_d    = state_q;
    prior_d    = prior_q;
    lu_cnt_d   = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    ctrl       = CTRL_RUN;
    // MEM_WAIT resumes whatever it interrupted, so decisions use that state.
    eff_state  = (state_q == MEM_WAIT) ? prior_q : state_q;
    wait_next  = (state_q == MEM_WAIT) ? ({1'b0, wait_cnt_q} + (WAIT_W+1)'(1))
                                       : (WAIT_W+1)'(1);
    if (state_q == HALT) begin
      ctrl = CTRL_FREEZE;
    end else if (mw) begin
      // Freeze everything; a taken branch in EX waits inside ID/EX.
      ctrl = CTRL_FREEZE;
      if (state_q != MEM_WAIT) prior_d = state_q;
      wait_cnt_d = wait_next[WAIT_W] ? '1 : wait_next[WAIT_W-1:0];
      if ((MEM_TIMEOUT != 0) && (wait_next >= TIMEOUT_V)) begin
        state_d = HALT;
        err_d   = 1'b1;
      end else begin
        state_d = MEM_WAIT;
      end
    end else begin
      wait_cnt_d = '0;
      state_d    = eff_state;
      if (ex_branch_taken) begin
        ctrl    = CTRL_BRANCH;
        state_d = RUN;
      end else if (eff_state == LU_STALL) begin
        ctrl = CTRL_STALL;
        if (lu_cnt_q == 2'd0) state_d = RUN;
        else lu_cnt_d = lu_cnt_q - 2'd1;
      end else if (lu) begin
        ctrl = CTRL_STALL;
        if (LOAD_DELAY > 1) begin
          state_d  = LU_STALL;
          lu_cnt_d = LU_RELOAD;
        end
      end else if (id_jump) begin
        ctrl = CTRL_JUMP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      prior_q    <= RUN;
      lu_cnt_q   <= 2'd0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prior_q    <= prior_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Controls are forced to free-running while reset is asserted.
  assign ctrl_out    = reset ? CTRL_RUN : ctrl;
  assign pc_write    = ctrl_out.pc_write;
  assign if_id_write = ctrl_out.if_id_write;
  assign if_id_flush = ctrl_out.if_id_flush;
  assign id_ex_flush = ctrl_out.id_ex_flush;
  assign id_ex_hold  = ctrl_out.id_ex_hold;
  assign ex_mem_hold = ctrl_out.ex_mem_hold;
  assign state       = state_q;
  assign err_timeout = err_q;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Every stall or freeze blocks the PC; every branch/jump flushes IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ctrl.pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (ctrl.if_id_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_DELAY=1/MEM_TIMEOUT=4 and
// LOAD_DELAY=3/MEM_TIMEOUT=0) share stimulus; a counter-based reference model
// is compared every cycle, plus directed literal expectations.
module tb_pipeline_hazard_ctrl;

  localparam int LD_A = 1;
  localparam int TO_A = 4;
  localparam int LD_B = 3;
  localparam int TO_B = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_dst;
  logic       id_use_rs, id_use_rt, id_jump, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready;

  logic [1:0][5:0] ctl;
  logic [1:0][1:0] st;
  logic [1:0]      err;
`ifdef HAZARD_PERF_EN
  logic [1:0][31:0] scnt, fcnt;
`endif

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_DELAY(LD_A), .MEM_TIMEOUT(TO_A), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_jump(id_jump),
    .ex_dst(ex_dst), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(ctl[0][5]), .if_id_write(ctl[0][4]), .if_id_flush(ctl[0][3]),
    .id_ex_flush(ctl[0][2]), .id_ex_hold(ctl[0][1]), .ex_mem_hold(ctl[0][0]),
    .state(st[0]), .err_timeout(err[0])
`ifdef HAZARD_PERF_EN
    , .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
`endif
  );

  pipeline_hazard_ctrl #(.LOAD_DELAY(LD_B), .MEM_TIMEOUT(TO_B), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_jump(id_jump),
    .ex_dst(ex_dst), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(ctl[1][5]), .if_id_write(ctl[1][4]), .if_id_flush(ctl[1][3]),
    .id_ex_flush(ctl[1][2]), .id_ex_hold(ctl[1][1]), .ex_mem_hold(ctl[1][0]),
    .state(st[1]), .err_timeout(err[1])
`ifdef HAZARD_PERF_EN
    , .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
`endif
  );

  // ---------------- reference model ----------------
  // halted: timeout hit; mw_run: consecutive wait cycles so far;
  // pending: load-use stall cycles still owed after the current cycle.
  int halted [2];
  int mw_run [2];
  int pending[2];
  longint exp_s[2];
  longint exp_f[2];
  logic [5:0] e_m;

  function automatic int dly(input int i);
    return (i == 0) ? LD_A : LD_B;
  endfunction

  function automatic int tmo(input int i);
    return (i == 0) ? TO_A : TO_B;
  endfunction

  function automatic bit lu_f();
    return ex_mem_read && (ex_dst != 5'd0) &&
           ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
  endfunction

  // bits: pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold
  function automatic logic [5:0] exp_ctrl(input int i);
    if (reset)                        return 6'b110000;
    if (halted[i] != 0)               return 6'b000011;
    if (mem_req && !mem_ready)        return 6'b000011;
    if (ex_branch_taken)              return 6'b111100;
    if (pending[i] > 0 || lu_f())     return 6'b000100;
    if (id_jump)                      return 6'b111000;
    return 6'b110000;
  endfunction

  function automatic int exp_state(input int i);
    if (halted[i] != 0) return 3;
    if (mw_run[i] > 0)  return 2;
    if (pending[i] > 0) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        halted[i] = 0; mw_run[i] = 0; pending[i] = 0; exp_s[i] = 0; exp_f[i] = 0;
      end else begin
        e_m = exp_ctrl(i);
        if (!e_m[5] && exp_s[i] < 64'hFFFF_FFFF) exp_s[i]++;
        if (e_m[3] && exp_f[i] < 64'hFFFF_FFFF) exp_f[i]++;
        if (halted[i] != 0) begin
          // stays halted until reset
        end else if (mem_req && !mem_ready) begin
          if (mw_run[i] < 1000) mw_run[i]++;
          if (tmo(i) != 0 && mw_run[i] >= tmo(i)) halted[i] = 1;
        end else begin
          mw_run[i] = 0;
          if (ex_branch_taken)    pending[i] = 0;
          else if (pending[i] > 0) pending[i]--;
          else if (lu_f())        pending[i] = dly(i) - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_ctrl[%0d]", i), 32'(ctl[i]), 32'(exp_ctrl(i)));
      chk($sformatf("model_state[%0d]", i), 32'(st[i]), 32'(exp_state(i)));
      chk($sformatf("model_err[%0d]", i), 32'(err[i]), 32'(halted[i] != 0));
`ifdef HAZARD_PERF_EN
      chk($sformatf("model_stall_cnt[%0d]", i), scnt[i], exp_s[i][31:0]);
      chk($sformatf("model_flush_cnt[%0d]", i), fcnt[i], exp_f[i][31:0]);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_jump = 1'b0;
    ex_dst = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic load_use();
    ex_mem_read = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic rand_inputs();
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    ex_dst = 5'($urandom_range(0, 3));
    id_use_rs = ($urandom_range(0, 99) < 60); id_use_rt = ($urandom_range(0, 99) < 60);
    ex_mem_read = ($urandom_range(0, 99) < 40);
    id_jump = ($urandom_range(0, 99) < 15);
    ex_branch_taken = ($urandom_range(0, 99) < 15);
    mem_req = ($urandom_range(0, 99) < 30);
    mem_ready = ($urandom_range(0, 99) < 50);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    mem_req = 1'b1; mem_ready = 1'b0; load_use();
    repeat (2) @(posedge clk);
    settle();
    chk("reset_ctrl_a", 32'(ctl[0]), 32'h30);
    chk("reset_state_a", 32'(st[0]), 0);
    chk("reset_err_a", 32'(err[0]), 0);
    next_cycle(); reset = 1'b0; idle();

    // load-use, one stall for A, three for B
    next_cycle(); load_use();
    settle(); chk("lu_a", 32'(ctl[0]), 32'h04); chk("lu_b", 32'(ctl[1]), 32'h04);
    next_cycle(); ex_mem_read = 1'b0;
    settle(); chk("lu_after_a", 32'(ctl[0]), 32'h30); chk("lu2_b", 32'(ctl[1]), 32'h04);
    chk("lu2_state_b", 32'(st[1]), 1);
    next_cycle();
    settle(); chk("lu3_b", 32'(ctl[1]), 32'h04);
    next_cycle();
    settle(); chk("lu_done_b", 32'(ctl[1]), 32'h30); chk("lu_done_state_b", 32'(st[1]), 0);

    // zero register / unused source do not stall
    next_cycle(); load_use(); ex_dst = 5'd0; id_rs = 5'd0;
    settle(); chk("lu_zero_reg", 32'(ctl[0]), 32'h30);
    next_cycle(); load_use(); id_use_rs = 1'b0; id_rt = 5'd8;
    settle(); chk("lu_unused_rs", 32'(ctl[0]), 32'h30);

    // branch beats load-use
    next_cycle(); idle(); load_use(); ex_branch_taken = 1'b1;
    settle(); chk("br_lu_a", 32'(ctl[0]), 32'h3C); chk("br_lu_b", 32'(ctl[1]), 32'h3C);
    next_cycle(); idle();
    settle(); chk("br_state_b", 32'(st[1]), 0);

    // LOAD_DELAY=3 interrupted by two wait cycles
    next_cycle(); load_use();
    settle(); chk("lumw0_b", 32'(ctl[1]), 32'h04);
    next_cycle(); idle(); mem_req = 1'b1; mem_ready = 1'b0;
    settle(); chk("lumw1_b", 32'(ctl[1]), 32'h03); chk("lumw1_state_b", 32'(st[1]), 1);
    next_cycle();
    settle(); chk("lumw2_b", 32'(ctl[1]), 32'h03); chk("lumw2_state_b", 32'(st[1]), 2);
    next_cycle(); idle();
    settle(); chk("lumw3_b", 32'(ctl[1]), 32'h04); chk("lumw3_state_b", 32'(st[1]), 2);
    next_cycle();
    settle(); chk("lumw4_b", 32'(ctl[1]), 32'h04); chk("lumw4_state_b", 32'(st[1]), 1);
    next_cycle();
    settle(); chk("lumw5_b", 32'(ctl[1]), 32'h30); chk("lumw5_state_b", 32'(st[1]), 0);

    // memory timeout on A
    next_cycle(); mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle(); chk("to_freeze_a", 32'(ctl[0]), 32'h03);
      next_cycle();
    end
    settle(); chk("to_state_a", 32'(st[0]), 3); chk("to_err_a", 32'(err[0]), 1);
    next_cycle(); idle();
    next_cycle();
    settle(); chk("halt_hold_a", 32'(ctl[0]), 32'h03); chk("halt_err_a", 32'(err[0]), 1);
    chk("halt_state_a", 32'(st[0]), 3);
    @(posedge clk); #2 reset = 1'b1;
    #1 chk("areset_state_a", 32'(st[0]), 0); chk("areset_err_a", 32'(err[0]), 0);
    chk("areset_ctrl_a", 32'(ctl[0]), 32'h30);
    settle(); reset = 1'b0;

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if ($urandom_range(0, 99) < 2) reset = 1'b1;
      else begin
        reset = 1'b0;
        rand_inputs();
      end
    end
    next_cycle(); reset = 1'b0; idle();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
